// File: rtl/draw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_pkg                                                             |
// | State encoding and window validation shared by the draw sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package draw_pkg;

   localparam int         c_STATE_W = 6;

   localparam logic [5:0] c_ST_IDLE  = 6'b000001;
   localparam logic [5:0] c_ST_FETCH = 6'b000010;
   localparam logic [5:0] c_ST_LATCH = 6'b000100;
   localparam logic [5:0] c_ST_SEND  = 6'b001000;
   localparam logic [5:0] c_ST_WAIT  = 6'b010000;
   localparam logic [5:0] c_ST_ADV   = 6'b100000;

   typedef enum logic [c_STATE_W-1:0] {
      ST_IDLE  = c_ST_IDLE,
      ST_FETCH = c_ST_FETCH,
      ST_LATCH = c_ST_LATCH,
      ST_SEND  = c_ST_SEND,
      ST_WAIT  = c_ST_WAIT,
      ST_ADV   = c_ST_ADV
   } state_t;

   // Inclusive bounds must be ordered and lie inside the frame.
   function automatic logic win_valid(
      input int unsigned x0,
      input int unsigned x1,
      input int unsigned y0,
      input int unsigned y1,
      input int unsigned h_res,
      input int unsigned v_res
   );
      return (x0 <= x1) && (y0 <= y1) && (x1 < h_res) && (y1 < v_res);
   endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | raster_counter                                                       |
// | Raster-order x/y/row_base walker over a latched inclusive window.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module raster_counter
   import draw_pkg::*;
#(
   parameter int H_RES  = 96,
   parameter int XW     = 7,
   parameter int YW     = 6,
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_reload,
   input  logic              i_step,
   input  logic [XW-1:0]     i_x0,
   input  logic [XW-1:0]     i_x1,
   input  logic [YW-1:0]     i_y0,
   input  logic [YW-1:0]     i_y1,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);

   localparam logic [ADDR_W-1:0] c_H_RES = ADDR_W'(H_RES);

   logic [XW-1:0]     r_x, r_x0, r_x1;
   logic [YW-1:0]     r_y, r_y0, r_y1;
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_base0;
   logic [ADDR_W-1:0] w_base_in;

   // Only multiply in the block: the starting row offset, once per start.
   assign w_base_in = ADDR_W'(i_y0) * c_H_RES;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_x0       <= '0;
         r_x1       <= '0;
         r_y0       <= '0;
         r_y1       <= '0;
         r_row_base <= '0;
         r_base0    <= '0;
      end else if (i_load) begin
         r_x0       <= i_x0;
         r_x1       <= i_x1;
         r_y0       <= i_y0;
         r_y1       <= i_y1;
         r_x        <= i_x0;
         r_y        <= i_y0;
         r_row_base <= w_base_in;
         r_base0    <= w_base_in;
      end else if (i_reload) begin
         r_x        <= r_x0;
         r_y        <= r_y0;
         r_row_base <= r_base0;
      end else if (i_step) begin
         if (r_x < r_x1) begin
            r_x <= r_x + XW'(1);
         end else if (r_y < r_y1) begin
            r_x        <= r_x0;
            r_y        <= r_y + YW'(1);
            r_row_base <= r_row_base + c_H_RES;
         end
      end
   end

   assign o_addr = r_row_base + ADDR_W'(r_x);
   assign o_last = (r_x == r_x1) && (r_y == r_y1);

endmodule
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_sequencer                                                       |
// | Walks a frame/window of pixel memory and feeds each word to the SPI. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module draw_sequencer
   import draw_pkg::*;
#(
   parameter int H_RES  = 96,
   parameter int V_RES  = 64,
   parameter int PIX_W  = 16,
   parameter int XW     = $clog2(H_RES),
   parameter int YW     = $clog2(V_RES),
   parameter int ADDR_W = $clog2(H_RES*V_RES)
) (
   input  logic              sck,
   input  logic              rst_in,
   input  logic              init_in,
   input  logic              abort_in,
   input  logic              cont_in,
   input  logic              win_en_in,
   input  logic [XW-1:0]     x0_in,
   input  logic [XW-1:0]     x1_in,
   input  logic [YW-1:0]     y0_in,
   input  logic [YW-1:0]     y1_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [PIX_W-1:0]  mem_data,
   output logic [PIX_W-1:0]  spi_data,
   output logic              spi_start,
   input  logic              spi_done,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [XW-1:0] c_X_MAX = XW'(H_RES - 1);
   localparam logic [YW-1:0] c_Y_MAX = YW'(V_RES - 1);

   state_t            r_state, w_next;
   logic              r_cont;
   logic [PIX_W-1:0]  r_spi_data;
   logic              r_done;
   logic              r_err;
   logic              w_load, w_reload, w_step;
   logic              w_valid, w_last;
   logic [XW-1:0]     w_x0, w_x1;
   logic [YW-1:0]     w_y0, w_y1;
   logic [ADDR_W-1:0] w_addr;

   assign w_x0 = win_en_in ? x0_in : '0;
   assign w_x1 = win_en_in ? x1_in : c_X_MAX;
   assign w_y0 = win_en_in ? y0_in : '0;
   assign w_y1 = win_en_in ? y1_in : c_Y_MAX;

   assign w_valid = win_valid(32'(w_x0), 32'(w_x1), 32'(w_y0), 32'(w_y1),
                              H_RES, V_RES);

   raster_counter #(
      .H_RES  (H_RES),
      .XW     (XW),
      .YW     (YW),
      .ADDR_W (ADDR_W)
   ) u_raster (
      .clk      (sck),
      .rst_n    (rst_in),
      .i_load   (w_load),
      .i_reload (w_reload),
      .i_step   (w_step),
      .i_x0     (w_x0),
      .i_x1     (w_x1),
      .i_y0     (w_y0),
      .i_y1     (w_y1),
      .o_addr   (w_addr),
      .o_last   (w_last)
   );

   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_reload = 1'b0;
      w_step   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (init_in && w_valid) begin
               w_next = ST_FETCH;
               w_load = 1'b1;
            end
         end
         ST_FETCH: w_next = ST_LATCH;
         ST_LATCH: w_next = ST_SEND;
         ST_SEND:  w_next = ST_WAIT;
         ST_WAIT: begin
            if (spi_done) begin
               w_next = ST_ADV;
            end
         end
         ST_ADV: begin
            if (!w_last) begin
               w_step = 1'b1;
               w_next = ST_FETCH;
            end else if (r_cont) begin
               w_reload = 1'b1;
               w_next   = ST_FETCH;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase

      // Abort wins over every other transition, including ADV bookkeeping.
      if (abort_in && (r_state != ST_IDLE)) begin
         w_next   = ST_IDLE;
         w_step   = 1'b0;
         w_reload = 1'b0;
      end
   end

   always_ff @(posedge sck or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // done is armed on the final spi_done so it is visible during ADV.
   always_ff @(posedge sck or negedge rst_in) begin
      if (!rst_in) begin
         r_cont     <= 1'b0;
         r_spi_data <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_load) begin
            r_cont <= cont_in;
         end
         if (r_state == ST_LATCH) begin
            r_spi_data <= mem_data;
         end
         r_done <= (r_state == ST_WAIT) && spi_done && !abort_in && w_last;
         r_err  <= (r_state == ST_IDLE) && init_in && !w_valid;
      end
   end

   assign mem_addr  = w_addr;
   assign mem_rd    = (r_state == ST_FETCH);
   assign spi_data  = r_spi_data;
   assign spi_start = (r_state == ST_SEND);
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_draw_sequencer                                                    |
// | Randomized self-checking bench against a raster-order window model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_draw_sequencer;

   localparam int c_H  = 12;
   localparam int c_V  = 8;
   localparam int c_XW = 4;
   localparam int c_YW = 3;
   localparam int c_AW = 7;
   localparam int c_PW = 16;

   logic            sck = 1'b0;
   logic            rst_in, init_in, abort_in, cont_in, win_en_in;
   logic [c_XW-1:0] x0_in, x1_in;
   logic [c_YW-1:0] y0_in, y1_in;
   logic [c_AW-1:0] mem_addr;
   logic            mem_rd;
   logic [c_PW-1:0] mem_data = '0;
   logic [c_PW-1:0] spi_data;
   logic            spi_start, spi_done, busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 sck = ~sck;

   draw_sequencer #(
      .H_RES (c_H),
      .V_RES (c_V),
      .PIX_W (c_PW)
   ) dut (
      .sck       (sck),
      .rst_in    (rst_in),
      .init_in   (init_in),
      .abort_in  (abort_in),
      .cont_in   (cont_in),
      .win_en_in (win_en_in),
      .x0_in     (x0_in),
      .x1_in     (x1_in),
      .y0_in     (y0_in),
      .y1_in     (y1_in),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .spi_data  (spi_data),
      .spi_start (spi_start),
      .spi_done  (spi_done),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   function automatic logic [15:0] pix(input int a);
      return 16'((a * 40503) ^ 23130);
   endfunction

   // Pixel memory: read data valid the cycle after the strobe.
   always @(posedge sck) begin
      if (mem_rd) begin
         mem_data <= pix(int'(mem_addr));
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic scramble_win();
      x0_in = c_XW'($urandom);
      x1_in = c_XW'($urandom);
      y0_in = c_YW'($urandom);
      y1_in = c_YW'($urandom);
   endtask

   task automatic start_req(input bit wen, input bit cont, input int x0, input int x1,
                            input int y0, input int y1);
      win_en_in = wen;
      cont_in   = cont;
      x0_in     = x0[c_XW-1:0];
      x1_in     = x1[c_XW-1:0];
      y0_in     = y0[c_YW-1:0];
      y1_in     = y1[c_YW-1:0];
      init_in   = 1'b1;
      @(negedge sck);
      init_in   = 1'b0;
   endtask

   // Entered at the negedge of the pixel's fetch cycle.
   // mode 0: normal, 1: abort with spi_done in WAIT, 2: reset during SEND.
   task automatic do_pixel(input int exp_addr, input bit exp_last, input int mode);
      int lat;
      check_eq("fetch_rd", mem_rd, 1);
      check_eq("fetch_addr", mem_addr, exp_addr);
      check_eq("fetch_err", err, 0);
      spi_done = 1'($urandom % 2);
      scramble_win();
      @(negedge sck);
      spi_done = 1'b0;
      check_eq("latch_start", spi_start, 0);
      check_eq("latch_rd", mem_rd, 0);
      @(negedge sck);
      check_eq("send_start", spi_start, 1);
      if (mode == 2) begin
         rst_in = 1'b0;
         #1;
         check_eq("rst_start", spi_start, 0);
         check_eq("rst_busy", busy, 0);
         check_eq("rst_addr", mem_addr, 0);
         @(negedge sck);
         rst_in = 1'b1;
         return;
      end
      lat = $urandom_range(1, 4);
      if (lat >= 2) spi_done = 1'($urandom % 2);
      for (int i = 1; i <= lat; i++) begin
         @(negedge sck);
         if (i == 1) begin
            check_eq("wait_start", spi_start, 0);
            init_in = 1'($urandom % 2);
         end
         if (i == lat) check_eq("wait_data", spi_data, pix(exp_addr));
         spi_done = (i == lat);
         if (mode == 1 && i == lat) abort_in = 1'b1;
      end
      if (mode == 1) begin
         @(negedge sck);
         abort_in = 1'b0;
         spi_done = 1'b0;
         init_in  = 1'b0;
         check_eq("abort_busy", busy, 0);
         check_eq("abort_done", done, 0);
         return;
      end
      @(negedge sck);
      spi_done = 1'b0;
      init_in  = 1'b0;
      check_eq("adv_done", done, exp_last);
      check_eq("adv_busy", busy, 1);
      check_eq("adv_data", spi_data, pix(exp_addr));
      @(negedge sck);
   endtask

   task automatic run_frame(input bit wen, input int x0, input int x1, input int y0, input int y1);
      int ex0, ex1, ey0, ey1;
      bit valid;
      if (wen) begin
         ex0 = x0 % 16; ex1 = x1 % 16; ey0 = y0 % 8; ey1 = y1 % 8;
      end else begin
         ex0 = 0; ex1 = c_H - 1; ey0 = 0; ey1 = c_V - 1;
      end
      valid = (ex0 <= ex1) && (ey0 <= ey1) && (ex1 < c_H) && (ey1 < c_V);
      start_req(wen, 1'b0, x0, x1, y0, y1);
      if (!valid) begin
         check_eq("inv_err", err, 1);
         check_eq("inv_busy", busy, 0);
         check_eq("inv_rd", mem_rd, 0);
         @(negedge sck);
         check_eq("inv_err_clr", err, 0);
         check_eq("inv_busy2", busy, 0);
         return;
      end
      for (int y = ey0; y <= ey1; y++) begin
         for (int x = ex0; x <= ex1; x++) begin
            do_pixel(y * c_H + x, (x == ex1) && (y == ey1), 0);
         end
      end
      check_eq("end_busy", busy, 0);
      check_eq("end_done", done, 0);
   endtask

   initial begin
      int x0, x1, y0, y1;
      rst_in    = 1'b0;
      init_in   = 1'b0;
      abort_in  = 1'b0;
      cont_in   = 1'b0;
      win_en_in = 1'b0;
      spi_done  = 1'b0;
      x0_in     = '0;
      x1_in     = '0;
      y0_in     = '0;
      y1_in     = '0;
      repeat (2) @(negedge sck);
      check_eq("rst_busy0", busy, 0);
      check_eq("rst_done0", done, 0);
      check_eq("rst_err0", err, 0);
      check_eq("rst_rd0", mem_rd, 0);
      check_eq("rst_start0", spi_start, 0);
      check_eq("rst_addr0", mem_addr, 0);
      check_eq("rst_data0", spi_data, 0);
      rst_in = 1'b1;
      @(negedge sck);

      run_frame(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 0, 0);
      run_frame(1'b1, 1, 2, 3, 4);
      run_frame(1'b1, 5, 3, 0, 0);
      run_frame(1'b1, 0, 12, 0, 0);

      for (int k = 0; k < 20; k++) begin
         x0 = $urandom_range(0, 11);
         x1 = (x0 + $urandom_range(0, 3)) % 16;
         if ($urandom % 6 == 0) x1 = $urandom_range(0, 15);
         y0 = $urandom_range(0, 7);
         y1 = y0 + $urandom_range(0, 2);
         if (y1 > 7) y1 = $urandom_range(0, 7);
         run_frame(($urandom % 5) != 0, x0, x1, y0, y1);
      end

      // Continuous refresh of a single pixel, then abort mid-transfer.
      start_req(1'b1, 1'b1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) do_pixel(0, 1'b1, 0);
      do_pixel(0, 1'b1, 1);
      repeat (3) begin
         @(negedge sck);
         check_eq("post_abort_done", done, 0);
         check_eq("post_abort_rd", mem_rd, 0);
      end

      // Asynchronous reset mid-frame, then a clean restart of the same window.
      start_req(1'b1, 1'b0, 2, 3, 1, 1);
      do_pixel(14, 1'b0, 0);
      do_pixel(15, 1'b0, 2);
      check_eq("after_rst_addr", mem_addr, 0);
      check_eq("after_rst_data", spi_data, 0);
      run_frame(1'b1, 2, 3, 1, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/draw_sequencer.md
# draw_sequencer

Parametrised frame/window pixel sequencer for the wb_static_screen display path. On a start request it walks a rectangular region of the pixel memory in raster order and reads one pixel per step. Each pixel is handed to the SPI transmitter through a start/done handshake. It generalises the single-frame draw controller with configurable resolution and pixel width, sub-window drawing, continuous refresh, abort, and window-error reporting.

## Interface
- H_RES, default 96: horizontal pixel count
- V_RES, default 64: vertical pixel count
- PIX_W, default 16: pixel / SPI word width
- XW, default $clog2(H_RES): x coordinate width
- YW, default $clog2(V_RES): y coordinate width
- ADDR_W, default $clog2(H_RES*V_RES): memory address width

Ports:
- sck  in  1  clock; all state updates on rising edge
- rst_in  in  1  asynchronous, active-low reset
- init_in  in  1  start request, sampled in IDLE only
- abort_in  in  1  stop request, honoured in any non-IDLE state
- cont_in  in  1  0: single frame; 1: continuous refresh
- win_en_in  in  1  0: full frame; 1: window x0..x1, y0..y1
- x0_in, x1_in  in  XW  window column bounds, inclusive
- y0_in, y1_in  in  YW  window row bounds, inclusive
- mem_addr  out  ADDR_W  pixel memory address
- mem_rd  out  1  memory read strobe; data valid one cycle later
- mem_data  in  PIX_W  pixel memory read data
- spi_data  out  PIX_W  word presented to SPI, held stable until spi_done
- spi_start  out  1  one-cycle transfer request
- spi_done  in  1  one-cycle pulse at end of SPI transfer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last pixel of each frame
- err  out  1  one-cycle pulse when a window is rejected

## Operation
- States: IDLE, FETCH, LATCH, SEND, WAIT, ADV.
- IDLE -> FETCH when init_in=1 and the window is valid.
  - Latch mode, window bounds, x=x0 and y=y0.
  - Set row_base = y0*H_RES.
  - In full-frame mode, bounds are 0..H_RES-1 and 0..V_RES-1.
- Window invalid when x0>x1, y0>y1, x1>=H_RES or y1>=V_RES. Response: err pulse; stay in IDLE.
- FETCH: mem_addr=row_base+x, mem_rd=1. Next state LATCH.
- LATCH: spi_data<=mem_data. Next state SEND.
- SEND: spi_start=1 for exactly one cycle. Next state WAIT.
- WAIT: hold until spi_done=1, then go to ADV.
- ADV:
  - If x<x1: x++, then FETCH.
  - Else if y<y1: x=x0, y++, row_base+=H_RES, then FETCH.
  - Else (last pixel): done=1 for one cycle.
    - With cont=1: reload x0/y0/row_base from the latched window, then FETCH.
    - With cont=0: go to IDLE.
- Window inputs are sampled only at start; mid-frame changes are ignored. Continuous mode re-draws the latched window.
- Address arithmetic is incremental (add only, no multiplier in the datapath). Only y0*H_RES at start may use a constant multiply.

## Timing
- Reset values:
  - State IDLE.
  - mem_addr, spi_data, x, y and row_base all 0.
  - mem_rd, spi_start, busy, done and err all 0.
- Outputs are registered or decoded from state only; no combinational input->output path.
- Start latency: init_in sampled at edge N gives mem_rd=1 in cycle N+1 and spi_start in cycle N+3.
- Per-pixel period is 4 + L cycles, where L is the number of WAIT cycles before spi_done.
- spi_done outside WAIT is ignored.
- abort_in=1 in any non-IDLE state:
  - Go to IDLE on the next edge; no done pulse.
  - An in-flight SPI transfer completes externally; its spi_done is ignored.
- abort_in takes precedence over spi_done in the same cycle, and over the ADV transition.
- init_in while busy is ignored.
- An asynchronous reset mid-frame forces all reset values immediately.
- A 1x1 window draws exactly one pixel, then pulses done.

## Structure
- Shared package draw_pkg:
  - State encoding localparams (one-hot, 6 bits).
  - A window-validity function.
- One natural sub-module, raster_counter: x/y/row_base counters with load, step, and last-pixel flag. The FSM and handshake stay in draw_sequencer.

## Test plan
- Full frame, H_RES=4, V_RES=2, cont=0, spi_done 2 cycles after each start -> addresses 0..7 in order, 8 spi_start pulses, one done pulse, busy falls the cycle after done.
- Window x0=1, x1=2, y0=3, y1=4 at 96x64 -> addresses 289, 290, 385, 386, then done.
- Invalid window x0=5, x1=3 -> err pulse one cycle after init_in, busy stays 0, no mem_rd.
- cont=1, 1x1 window at (0,0) -> repeated address-0 transfers, done pulse per pixel; abort asserted during WAIT -> IDLE next edge, no further done.
- rst_in asserted low during SEND -> spi_start, busy and mem_addr go to 0 immediately; a later init_in restarts from x0/y0.
- spi_done pulsed in FETCH and SEND -> ignored; spi_data stays stable until the legitimate spi_done arrives in WAIT.
